// File: rtl/aftab_aau_sequencer.sv
// aftab_aau_sequencer
//   Sequences aftab_AAU for the RV32M multiply/divide group on behalf of the
//   core controller. It latches the operands, selects the AAU mode and start
//   signal, waits for completeAAU and returns either the H or the L half.
//   Divide-by-zero and signed-overflow divides are resolved here without
//   starting the AAU. A WAIT that runs past TIMEOUT_CYCLES is aborted with err.
//
// Ports
//   clk, rst         clock; asynchronous active-low reset
//   req, funct3      request and RV32M funct3 (sampled only in IDLE)
//   rs1, rs2         operands
//   busy, done       in-flight flag; one-cycle completion pulse
//   result, dz, err  result word, divide-by-zero flag, timeout flag
//   aauA, aauB       operands driven to the AAU
//   multAAU, divideAAU                                  AAU start strobes
//   signedSigned, signedUnsigned, unsignedUnsigned      AAU mode select
//   aauH, aauL, completeAAU, dev0                       AAU results/status
module aftab_aau_sequencer #(
  parameter int START_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 80
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic [2:0]  funct3,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        dz,
  output logic        err,
  output logic [31:0] aauA,
  output logic [31:0] aauB,
  output logic        multAAU,
  output logic        divideAAU,
  output logic        signedSigned,
  output logic        signedUnsigned,
  output logic        unsignedUnsigned,
  input  logic [31:0] aauH,
  input  logic [31:0] aauL,
  input  logic        completeAAU,
  input  logic        dev0
);

  localparam int SC_W = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;
  localparam int TC_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [SC_W-1:0] START_LAST = SC_W'(START_CYCLES - 1);
  localparam logic [TC_W-1:0] TMO_LAST   = TC_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LAUNCH, S_WAIT, S_BYPASS, S_DONE
  } state_t;

  state_t          state;
  logic [2:0]      f3_q;
  logic            byp_dz_q;
  logic [SC_W-1:0] st_cnt;
  logic [TC_W-1:0] tmo_cnt;

  logic is_div, div_zero, div_ovf;

  // {signedSigned, signedUnsigned, unsignedUnsigned}
  function automatic logic [2:0] mode_of(input logic [2:0] f3);
    case (f3)
      3'b010:                 mode_of = 3'b010;
      3'b011, 3'b101, 3'b111: mode_of = 3'b001;
      default:                mode_of = 3'b100;
    endcase
  endfunction

  // MUL and DIV/DIVU take the low word; MULH* and REM/REMU take the high word.
  function automatic logic [31:0] pick_half(input logic [2:0] f3,
                                            input logic [31:0] h,
                                            input logic [31:0] l);
    logic take_h;
    take_h    = f3[2] ? f3[1] : (f3 != 3'b000);
    pick_half = take_h ? h : l;
  endfunction

  // RISC-V divide-by-zero: quotient all ones, remainder is the dividend.
  function automatic logic [31:0] dz_result(input logic [2:0] f3,
                                            input logic [31:0] a);
    dz_result = f3[1] ? a : 32'hFFFF_FFFF;
  endfunction

  // Signed overflow (most-negative / -1): quotient is the dividend, remainder 0.
  function automatic logic [31:0] ovf_result(input logic [2:0] f3);
    ovf_result = f3[1] ? 32'h0000_0000 : 32'h8000_0000;
  endfunction

  assign is_div   = funct3[2];
  assign div_zero = is_div && (rs2 == 32'h0000_0000);
  // Only the signed forms (DIV=100, REM=110) can overflow.
  assign div_ovf  = is_div && !funct3[0] &&
                    (rs1 == 32'h8000_0000) && (rs2 == 32'hFFFF_FFFF);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= S_IDLE;
      f3_q             <= 3'b000;
      byp_dz_q         <= 1'b0;
      st_cnt           <= '0;
      tmo_cnt          <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      result           <= 32'h0;
      dz               <= 1'b0;
      err              <= 1'b0;
      aauA             <= 32'h0;
      aauB             <= 32'h0;
      multAAU          <= 1'b0;
      divideAAU        <= 1'b0;
      signedSigned     <= 1'b0;
      signedUnsigned   <= 1'b0;
      unsignedUnsigned <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req) begin
            f3_q    <= funct3;
            aauA    <= rs1;
            aauB    <= rs2;
            busy    <= 1'b1;
            dz      <= 1'b0;
            err     <= 1'b0;
            st_cnt  <= '0;
            tmo_cnt <= '0;
            {signedSigned, signedUnsigned, unsignedUnsigned} <= mode_of(funct3);
            if (div_zero || div_ovf) begin
              byp_dz_q <= div_zero;
              state    <= S_BYPASS;
            end else begin
              // Start strobe rises together with entry into LAUNCH.
              multAAU   <= !funct3[2];
              divideAAU <= funct3[2];
              state     <= S_LAUNCH;
            end
          end
        end

        S_LAUNCH: begin
          if (st_cnt == START_LAST) begin
            multAAU   <= 1'b0;
            divideAAU <= 1'b0;
            state     <= S_WAIT;
          end else begin
            st_cnt <= st_cnt + SC_W'(1);
          end
        end

        S_WAIT: begin
          // completeAAU takes priority over a coincident timeout.
          if (completeAAU) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
            if (dev0 && f3_q[2]) begin
              result <= dz_result(f3_q, aauA);
              dz     <= 1'b1;
            end else begin
              result <= pick_half(f3_q, aauH, aauL);
            end
          end else if (tmo_cnt == TMO_LAST) begin
            busy   <= 1'b0;
            done   <= 1'b1;
            result <= 32'h0;
            err    <= 1'b1;
            state  <= S_DONE;
          end else begin
            tmo_cnt <= tmo_cnt + TC_W'(1);
          end
        end

        S_BYPASS: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= S_DONE;
          if (byp_dz_q) begin
            result <= dz_result(f3_q, aauA);
            dz     <= 1'b1;
          end else begin
            result <= ovf_result(f3_q);
          end
        end

        S_DONE: begin
          // A req seen here is not accepted; IDLE samples it next cycle.
          done             <= 1'b0;
          signedSigned     <= 1'b0;
          signedUnsigned   <= 1'b0;
          unsignedUnsigned <= 1'b0;
          state            <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aftab_aau_sequencer.sv
// Testbench for aftab_aau_sequencer: directed RV32M operations against a
// behavioural AAU, with expected results queued per request and compared
// when done pulses.
module tb_aftab_aau_sequencer;

  localparam int START_CYCLES   = 2;
  localparam int TIMEOUT_CYCLES = 80;
  localparam int AAU_LAT        = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] rs1 = 32'h0, rs2 = 32'h0;
  logic        busy, done, dz, err;
  logic [31:0] result, aauA, aauB;
  logic        multAAU, divideAAU, signedSigned, signedUnsigned, unsignedUnsigned;
  logic [31:0] aauH = 32'h0, aauL = 32'h0;
  logic        completeAAU = 1'b0, dev0 = 1'b0;

  aftab_aau_sequencer #(
    .START_CYCLES  (START_CYCLES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .funct3(funct3), .rs1(rs1), .rs2(rs2),
    .busy(busy), .done(done), .result(result), .dz(dz), .err(err),
    .aauA(aauA), .aauB(aauB), .multAAU(multAAU), .divideAAU(divideAAU),
    .signedSigned(signedSigned), .signedUnsigned(signedUnsigned),
    .unsignedUnsigned(unsignedUnsigned), .aauH(aauH), .aauL(aauL),
    .completeAAU(completeAAU), .dev0(dev0)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] res;
    logic        dz;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  bit   hang = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Behavioural AAU: full 64-bit product or quotient/remainder.
  function automatic logic [63:0] aau_calc(input logic [31:0] a, input logic [31:0] b,
                                           input logic is_div, input logic ss,
                                           input logic su);
    logic [63:0] ax, bx;
    int          sa, sb_i;
    logic [31:0] q, r;
    if (!is_div) begin
      ax = (ss || su) ? {{32{a[31]}}, a} : {32'h0, a};
      bx = ss ? {{32{b[31]}}, b} : {32'h0, b};
      return ax * bx;
    end
    if (b == 32'h0) return {a, 32'hFFFF_FFFF};
    if (ss) begin
      sa   = a;
      sb_i = b;
      q    = 32'(sa / sb_i);
      r    = 32'(sa % sb_i);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  bit          pend = 1'b0;
  int          cnt = 0;
  logic [63:0] hl = 64'h0;

  always @(negedge clk) begin
    if (!rst) begin
      pend        = 1'b0;
      completeAAU = 1'b0;
    end else begin
      completeAAU = 1'b0;
      if (multAAU || divideAAU) begin
        pend = 1'b1;
        cnt  = AAU_LAT;
        hl   = aau_calc(aauA, aauB, divideAAU, signedSigned, signedUnsigned);
      end else if (pend && !hang) begin
        if (cnt <= 1) begin
          completeAAU = 1'b1;
          aauH        = hl[63:32];
          aauL        = hl[31:0];
          pend        = 1'b0;
        end else begin
          cnt--;
        end
      end
    end
  end

  // Scoreboard consumer: every done must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst && done) begin
      if (sb.size() == 0) begin
        chk("spurious_done", {31'h0, done}, 32'h0);
      end else begin
        e = sb.pop_front();
        chk("result", result, e.res);
        chk("dz", {31'h0, dz}, {31'h0, e.dz});
        chk("err", {31'h0, err}, {31'h0, e.err});
      end
    end
  end

  task automatic run_op(input string name, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] er, input logic edz, input logic eerr,
                        input logic [2:0] emode, input int elat, input int estarts);
    exp_t e;
    int   n = 0, mc = 0, dcn = 0;
    e.res = er;
    e.dz  = edz;
    e.err = eerr;
    sb.push_back(e);
    @(posedge clk); #1;
    req = 1'b1; funct3 = f3; rs1 = a; rs2 = b;
    @(posedge clk); #1;
    // Operand changes while busy must have no effect.
    req = 1'b0; funct3 = 3'($urandom); rs1 = $urandom; rs2 = $urandom;
    while (n < 300) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        chk({name, "_busy"}, {31'h0, busy}, 32'h1);
        chk({name, "_mode"}, {29'h0, signedSigned, signedUnsigned, unsignedUnsigned},
            {29'h0, emode});
      end
      if (multAAU) mc++;
      if (divideAAU) dcn++;
      if (done) break;
    end
    chk({name, "_done_seen"}, {31'h0, done}, 32'h1);
    if (elat > 0) chk({name, "_latency"}, 32'(n), 32'(elat));
    chk({name, "_mult_cycles"}, 32'(mc), f3[2] ? 32'd0 : 32'(estarts));
    chk({name, "_div_cycles"}, 32'(dcn), f3[2] ? 32'(estarts) : 32'd0);
    @(negedge clk);
    chk({name, "_done_pulse"}, {30'h0, done, busy}, 32'h0);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("reset_ctrl", {23'h0, busy, done, dz, err, multAAU, divideAAU,
                       signedSigned, signedUnsigned, unsignedUnsigned}, 32'h0);
    chk("reset_result", result, 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;

    run_op("mul",    3'b000, 32'd40,        32'hFFFF_FFFE, 32'hFFFF_FFB0, 1'b0, 1'b0, 3'b100, 0, START_CYCLES);
    run_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 1'b0, 1'b0, 3'b010, 0, START_CYCLES);
    run_op("mulhu",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 1'b0, 3'b001, 0, START_CYCLES);
    run_op("div",    3'b100, 32'hFFFF_FF88, 32'd7,         32'hFFFF_FFEF, 1'b0, 1'b0, 3'b100, 0, START_CYCLES);
    run_op("rem",    3'b110, 32'hFFFF_FF88, 32'd7,         32'hFFFF_FFFF, 1'b0, 1'b0, 3'b100, 0, START_CYCLES);
    run_op("divu",   3'b101, 32'd121,       32'd7,         32'd17,        1'b0, 1'b0, 3'b001, 0, START_CYCLES);
    run_op("remu",   3'b111, 32'd121,       32'd7,         32'd2,         1'b0, 1'b0, 3'b001, 0, START_CYCLES);
    run_op("div_z",  3'b100, 32'd5,         32'd0,         32'hFFFF_FFFF, 1'b1, 1'b0, 3'b100, 2, 0);
    run_op("remu_z", 3'b111, 32'd5,         32'd0,         32'd5,         1'b1, 1'b0, 3'b001, 2, 0);
    run_op("div_ov", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1'b0, 3'b100, 2, 0);
    run_op("rem_ov", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1'b0, 1'b0, 3'b100, 2, 0);

    // AAU never completes: 2 LAUNCH + 80 WAIT cycles, then DONE.
    hang = 1'b1;
    run_op("timeout", 3'b000, 32'd6, 32'd7, 32'h0, 1'b0, 1'b1, 3'b100,
           START_CYCLES + TIMEOUT_CYCLES + 1, START_CYCLES);
    hang = 1'b0;
    run_op("mul2", 3'b000, 32'd6, 32'd7, 32'd42, 1'b0, 1'b0, 3'b100, 0, START_CYCLES);

    // Reset in the middle of WAIT
    hang = 1'b1;
    @(posedge clk); #1;
    req = 1'b1; funct3 = 3'b000; rs1 = 32'd3; rs2 = 32'd5;
    @(posedge clk); #1;
    req = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("midrst_ctrl", {23'h0, busy, done, dz, err, multAAU, divideAAU,
                        signedSigned, signedUnsigned, unsignedUnsigned}, 32'h0);
    chk("midrst_result", result, 32'h0);
    chk("midrst_aau_ops", aauA | aauB, 32'h0);
    @(posedge clk); #1;
    rst  = 1'b1;
    hang = 1'b0;
    repeat (4) @(negedge clk);
    chk("midrst_no_done", {31'h0, done}, 32'h0);
    run_op("mulh_after_rst", 3'b001, 32'h8000_0000, 32'd2, 32'hFFFF_FFFF, 1'b0, 1'b0, 3'b100, 0, START_CYCLES);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
